// File: rtl/demux_pkg.sv
// Shared types for the 1-to-3 byte router: one-hot destination codes and
// the FIFO entry layout.
package demux_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    DEST_FIRST  = 3'b001,
    DEST_SECOND = 3'b010,
    DEST_THIRD  = 3'b100
  } dest_t;

  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] data;
    dest_t                    dest;
  } entry_t;

  function automatic logic is_one_hot(input logic [2:0] sel);
    return $onehot(sel);
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// In-order synchronous FIFO of routed entries; the caller guarantees no push
// when full and no pop when empty.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign fill = count;

endmodule

// File: rtl/demux_1_to_3_8.sv
// Buffered 1-to-3 byte router: validates the one-hot select, queues beats in
// order, and presents the head beat to its destination over valid/ready.
module demux_1_to_3_8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel_first,
  input  logic                   in_sel_second,
  input  logic                   in_sel_third,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_first,
  output logic [WIDTH-1:0]       out_second,
  output logic [WIDTH-1:0]       out_third,
  output logic                   out_valid_first,
  output logic                   out_valid_second,
  output logic                   out_valid_third,
  input  logic                   out_ready_first,
  input  logic                   out_ready_second,
  input  logic                   out_ready_third,
  output logic                   sel_err,
  output logic [$clog2(DEPTH):0] fill
);

  import demux_pkg::*;

  localparam int unsigned  CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2:0]       sel;
  logic             take;
  logic             push;
  logic             pop;
  logic             empty;
  entry_t           head;
  entry_t           push_entry;
  logic [WIDTH-1:0] hold_first;
  logic [WIDTH-1:0] hold_second;
  logic [WIDTH-1:0] hold_third;

  assign sel      = {in_sel_third, in_sel_second, in_sel_first};
  assign in_ready = (fill < FULL);
  assign take     = in_valid && in_ready;
  assign push     = take && is_one_hot(sel);

  assign push_entry.data = in_data;
  assign push_entry.dest = dest_t'(sel);

  demux_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .fill       (fill)
  );

  assign empty            = (fill == '0);
  assign out_valid_first  = !empty && (head.dest == DEST_FIRST);
  assign out_valid_second = !empty && (head.dest == DEST_SECOND);
  assign out_valid_third  = !empty && (head.dest == DEST_THIRD);

  assign pop = (out_valid_first  && out_ready_first)  ||
               (out_valid_second && out_ready_second) ||
               (out_valid_third  && out_ready_third);

  // Each port shows the pending head byte, else the last byte it consumed.
  assign out_first  = out_valid_first  ? head.data : hold_first;
  assign out_second = out_valid_second ? head.data : hold_second;
  assign out_third  = out_valid_third  ? head.data : hold_third;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_first  <= '0;
      hold_second <= '0;
      hold_third  <= '0;
      sel_err     <= 1'b0;
    end else begin
      if (out_valid_first && out_ready_first) begin
        hold_first <= head.data;
      end
      if (out_valid_second && out_ready_second) begin
        hold_second <= head.data;
      end
      if (out_valid_third && out_ready_third) begin
        hold_third <= head.data;
      end
      if (take && !is_one_hot(sel)) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_1_to_3_8.sv
// Self-checking bench for demux_1_to_3_8: directed vector table, async reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_demux_1_to_3_8;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic [2:0] sel = '0;
  logic       in_valid = 1'b0;
  logic [2:0] rdy = '0;
  logic       in_ready;
  logic [7:0] out_first, out_second, out_third;
  logic       out_valid_first, out_valid_second, out_valid_third;
  logic       sel_err;
  logic [1:0] fill;

  demux_1_to_3_8 #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_data          (in_data),
    .in_sel_first     (sel[0]),
    .in_sel_second    (sel[1]),
    .in_sel_third     (sel[2]),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .out_first        (out_first),
    .out_second       (out_second),
    .out_third        (out_third),
    .out_valid_first  (out_valid_first),
    .out_valid_second (out_valid_second),
    .out_valid_third  (out_valid_third),
    .out_ready_first  (rdy[0]),
    .out_ready_second (rdy[1]),
    .out_ready_third  (rdy[2]),
    .sel_err          (sel_err),
    .fill             (fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned dest;
  } beat_t;

  beat_t      q[$];
  logic [7:0] m_hold[3];
  logic       m_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [2:0] dut_vld;
  logic [7:0] dut_out[3];
  always_comb begin
    dut_vld    = {out_valid_third, out_valid_second, out_valid_first};
    dut_out[0] = out_first;
    dut_out[1] = out_second;
    dut_out[2] = out_third;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int d = 0; d < 3; d++) m_hold[d] = 8'h00;
    m_err = 1'b0;
  endtask

  // Reference behaviour at a rising edge, from the current inputs and model state.
  task automatic model_edge();
    bit take;
    beat_t b;
    take = in_valid && (q.size() < DEPTH);
    if (q.size() > 0 && rdy[q[0].dest]) begin
      m_hold[q[0].dest] = q[0].data;
      void'(q.pop_front());
    end
    if (take) begin
      if ($countones(sel) == 1) begin
        b.data = in_data;
        b.dest = sel[0] ? 0 : (sel[1] ? 1 : 2);
        q.push_back(b);
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [2:0] ev;
    logic [7:0] eo;
    ev = '0;
    if (q.size() > 0) ev[q[0].dest] = 1'b1;
    chk({tag, ".in_ready"}, in_ready, (q.size() < DEPTH));
    chk({tag, ".fill"}, fill, q.size());
    chk({tag, ".out_valid"}, dut_vld, ev);
    for (int d = 0; d < 3; d++) begin
      if (ev[d]) eo = q[0].data;
      else       eo = m_hold[d];
      chk($sformatf("%s.out%0d", tag, d), dut_out[d], eo);
    end
    chk({tag, ".sel_err"}, sel_err, m_err);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    logic       valid;
    logic [2:0] rdy;
    logic       e_ir;
    logic [1:0] e_fill;
    logic [2:0] e_vld;
    logic [7:0] e_o1, e_o2, e_o3;
    logic       e_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // inputs for one cycle, then the state expected after that edge
    vecs[0]  = '{8'hA5, 3'b010, 1'b1, 3'b111, 1'b1, 2'd1, 3'b010, 8'h00, 8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{8'h00, 3'b000, 1'b0, 3'b111, 1'b1, 2'd0, 3'b000, 8'h00, 8'hA5, 8'h00, 1'b0};
    vecs[2]  = '{8'h11, 3'b100, 1'b1, 3'b011, 1'b1, 2'd1, 3'b100, 8'h00, 8'hA5, 8'h11, 1'b0};
    vecs[3]  = '{8'h22, 3'b001, 1'b1, 3'b011, 1'b0, 2'd2, 3'b100, 8'h00, 8'hA5, 8'h11, 1'b0};
    vecs[4]  = '{8'h33, 3'b010, 1'b1, 3'b011, 1'b0, 2'd2, 3'b100, 8'h00, 8'hA5, 8'h11, 1'b0};
    vecs[5]  = '{8'h33, 3'b010, 1'b1, 3'b111, 1'b1, 2'd1, 3'b001, 8'h22, 8'hA5, 8'h11, 1'b0};
    vecs[6]  = '{8'h33, 3'b010, 1'b1, 3'b111, 1'b1, 2'd1, 3'b010, 8'h22, 8'h33, 8'h11, 1'b0};
    vecs[7]  = '{8'h00, 3'b000, 1'b0, 3'b111, 1'b1, 2'd0, 3'b000, 8'h22, 8'h33, 8'h11, 1'b0};
    vecs[8]  = '{8'h44, 3'b011, 1'b1, 3'b111, 1'b1, 2'd0, 3'b000, 8'h22, 8'h33, 8'h11, 1'b1};
    vecs[9]  = '{8'h55, 3'b000, 1'b1, 3'b111, 1'b1, 2'd0, 3'b000, 8'h22, 8'h33, 8'h11, 1'b1};
    vecs[10] = '{8'h00, 3'b000, 1'b0, 3'b111, 1'b1, 2'd0, 3'b000, 8'h22, 8'h33, 8'h11, 1'b1};

    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model("reset");

    for (int i = 0; i < 11; i++) begin
      in_data  = vecs[i].data;
      sel      = vecs[i].sel;
      in_valid = vecs[i].valid;
      rdy      = vecs[i].rdy;
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("vec%0d.fill", i), fill, vecs[i].e_fill);
      chk($sformatf("vec%0d.out_valid", i), dut_vld, vecs[i].e_vld);
      chk($sformatf("vec%0d.out_first", i), out_first, vecs[i].e_o1);
      chk($sformatf("vec%0d.out_second", i), out_second, vecs[i].e_o2);
      chk($sformatf("vec%0d.out_third", i), out_third, vecs[i].e_o3);
      chk($sformatf("vec%0d.sel_err", i), sel_err, vecs[i].e_err);
    end

    // Fill to DEPTH with first as head, then drop rst_n between edges.
    rdy      = 3'b000;
    in_valid = 1'b1;
    in_data  = 8'h66;
    sel      = 3'b001;
    tick("fillA");
    in_data  = 8'h77;
    sel      = 3'b100;
    tick("fillB");
    in_valid = 1'b0;
    chk("midrst.pre_fill", fill, 2'd2);
    chk("midrst.pre_valid_first", out_valid_first, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.fill", fill, 2'd0);
    chk("midrst.out_valid", dut_vld, 3'b000);
    chk("midrst.out_first", out_first, 8'h00);
    chk("midrst.out_second", out_second, 8'h00);
    chk("midrst.out_third", out_third, 8'h00);
    chk("midrst.sel_err", sel_err, 1'b0);
    chk("midrst.in_ready", in_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_model("post_rst");

    for (int i = 0; i < 600; i++) begin
      in_data = 8'($urandom);
      if ($urandom_range(0, 5) != 0) sel = 3'(3'b001 << $urandom_range(0, 2));
      else                           sel = 3'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      rdy      = 3'($urandom);
      if ($urandom_range(0, 3) == 0) rdy = 3'b111;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
